// File: rtl/datapath_player.sv
// Player-ship datapath: owns the ship row, applies move strobes, and turns sprite pixel
// offsets into registered VGA writes. Define PLAYER_WRAP_EN to make moves wrap at the edges.
module datapath_player #(
  parameter logic [7:0] X_POS  = 8'd4,
  parameter logic [6:0] Y_INIT = 7'd58,
  parameter logic [6:0] Y_MIN  = 7'd0,
  parameter logic [6:0] Y_MAX  = 7'd117,
  parameter logic [6:0] STEP   = 7'd1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       y_pos_mod,
  input  logic       y_neg_mod,
  input  logic       add_x,
  input  logic [1:0] add_y,
  input  logic [2:0] colour_in,
  input  logic       write_en,
  input  logic       continue_draw,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic [6:0] ship_y,
  output logic       at_top,
  output logic       at_bottom,
  output logic       frame_done
);

`ifdef PLAYER_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [2:0] PIX_FULL = 3'd6;

  logic [6:0] ship_y_reg, y_next;
  logic [7:0] x_out_reg, x_next;
  logic [6:0] y_out_reg, y_out_next;
  logic [2:0] colour_reg;
  logic       plot_reg, plot_next;
  logic [2:0] pix_cnt_reg, pix_cnt_next;
  logic       frame_done_reg, frame_done_next;
  logic [7:0] y_down_wide;
  logic       move;

  // Idle/ending indication carries no datapath action; the counter simply holds.
  logic unused_continue_draw;
  assign unused_continue_draw = continue_draw;

  assign move        = y_pos_mod | y_neg_mod;
  assign y_down_wide = {1'b0, ship_y_reg} + {1'b0, STEP};

  always_comb begin
    y_next = ship_y_reg;
    if (y_pos_mod && !y_neg_mod) begin
      // Compare before subtracting so the 7-bit row never underflows.
      if ({1'b0, ship_y_reg} < ({1'b0, Y_MIN} + {1'b0, STEP}))
        y_next = WRAP_EN ? Y_MAX : Y_MIN;
      else
        y_next = ship_y_reg - STEP;
    end else if (y_neg_mod && !y_pos_mod) begin
      if (y_down_wide > {1'b0, Y_MAX})
        y_next = WRAP_EN ? Y_MIN : Y_MAX;
      else
        y_next = y_down_wide[6:0];
    end
  end

  always_comb begin
    x_next     = X_POS + {7'd0, add_x};
    y_out_next = y_next + {5'd0, add_y};
    plot_next  = write_en && (add_y != 2'd3);
  end

  always_comb begin
    pix_cnt_next    = pix_cnt_reg;
    frame_done_next = 1'b0;
    if (move) begin
      pix_cnt_next = write_en ? 3'd1 : 3'd0;
    end else if (write_en) begin
      if (pix_cnt_reg >= PIX_FULL) begin
        pix_cnt_next = PIX_FULL;
      end else begin
        pix_cnt_next    = pix_cnt_reg + 3'd1;
        frame_done_next = (pix_cnt_reg == 3'd5);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ship_y_reg     <= Y_INIT;
      x_out_reg      <= 8'd0;
      y_out_reg      <= 7'd0;
      colour_reg     <= 3'd0;
      plot_reg       <= 1'b0;
      pix_cnt_reg    <= 3'd0;
      frame_done_reg <= 1'b0;
    end else begin
      ship_y_reg     <= y_next;
      x_out_reg      <= x_next;
      y_out_reg      <= y_out_next;
      colour_reg     <= colour_in;
      plot_reg       <= plot_next;
      pix_cnt_reg    <= pix_cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign ship_y     = ship_y_reg;
  assign at_top     = (ship_y_reg == Y_MIN);
  assign at_bottom  = (ship_y_reg == Y_MAX);
  assign x_out      = x_out_reg;
  assign y_out      = y_out_reg;
  assign colour_out = colour_reg;
  assign plot       = plot_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_datapath_player.sv
// Scoreboard bench for datapath_player: expected VGA writes and ship state are queued
// at drive time and compared one cycle later. Honours PLAYER_WRAP_EN for boundary moves.
module tb_datapath_player;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       y_pos_mod, y_neg_mod, add_x, write_en, continue_draw;
  logic [1:0] add_y;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [6:0] y_out, ship_y;
  logic [2:0] colour_out;
  logic       plot, at_top, at_bottom, frame_done;

  always #5 clk = ~clk;

  datapath_player dut (
    .clk(clk), .reset_n(reset_n),
    .y_pos_mod(y_pos_mod), .y_neg_mod(y_neg_mod),
    .add_x(add_x), .add_y(add_y), .colour_in(colour_in),
    .write_en(write_en), .continue_draw(continue_draw),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
    .ship_y(ship_y), .at_top(at_top), .at_bottom(at_bottom), .frame_done(frame_done)
  );

`ifdef PLAYER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    int x, y, c, plot, fd, sy;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   txn           = 0;

  // Reference model state
  int model_y   = 58;
  int model_pix = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s txn=%0d got=%0d exp=%0d", tag, txn, got, exp);
  endtask

  task automatic step(input bit up, input bit dn, input bit ax, input int ay,
                      input int col, input bit we);
    exp_t e;
    int   ny;
    bit   mv;
    y_pos_mod = up; y_neg_mod = dn; add_x = ax; add_y = 2'(ay);
    colour_in = 3'(col); write_en = we; continue_draw = !we && !up && !dn;
    mv = up || dn;
    ny = model_y;
    if (up && !dn) begin
      ny = model_y - 1;
      if (ny < 0) ny = WRAP ? 117 : 0;
    end else if (dn && !up) begin
      ny = model_y + 1;
      if (ny > 117) ny = WRAP ? 0 : 117;
    end
    e.x    = 4 + int'(ax);
    e.y    = ny + ay;
    e.c    = col;
    e.plot = (we && ay != 3) ? 1 : 0;
    e.fd   = (!mv && we && model_pix == 5) ? 1 : 0;
    e.sy   = ny;
    if (mv) model_pix = we ? 1 : 0;
    else if (we && model_pix < 6) model_pix++;
    model_y = ny;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    txn++;
    if (exp_q.size() == 0) begin
      check_value("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      $display("txn %0d x=%0d y=%0d c=%0d plot=%0d fd=%0d ship_y=%0d",
               txn, x_out, y_out, colour_out, plot, frame_done, ship_y);
      check_value("x_out", int'(x_out), e.x);
      check_value("y_out", int'(y_out), e.y);
      check_value("colour_out", int'(colour_out), e.c);
      check_value("plot", int'(plot), e.plot);
      check_value("frame_done", int'(frame_done), e.fd);
      check_value("ship_y", int'(ship_y), e.sy);
      check_value("at_top", int'(at_top), (e.sy == 0) ? 1 : 0);
      check_value("at_bottom", int'(at_bottom), (e.sy == 117) ? 1 : 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    y_pos_mod = 0; y_neg_mod = 0; add_x = 0; add_y = 0;
    colour_in = 0; write_en = 0; continue_draw = 0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_x_out", int'(x_out), 0);
    check_value("rst_y_out", int'(y_out), 0);
    check_value("rst_plot", int'(plot), 0);
    #4 reset_n = 1'b1;
    #1;
    check_value("rst_ship_y", int'(ship_y), 58);
    check_value("rst_frame_done", int'(frame_done), 0);
    check_value("rst_at_top", int'(at_top), 0);
    check_value("rst_at_bottom", int'(at_bottom), 0);

    // Up move plus full sprite
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 7, 1);
    step(0, 0, 1, 1, 7, 1);
    step(0, 0, 0, 2, 0, 1);
    step(0, 0, 1, 2, 0, 1);
    check_value("up_ship_y", int'(ship_y), 57);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);   // saturated counter: no second pulse

    // Simultaneous strobes then illegal offset, completing a sprite
    step(1, 1, 1, 2, 5, 1);
    step(0, 0, 0, 3, 2, 1);
    for (int i = 0; i < 4; i++) step(0, 0, i[0], i % 3, i, 1);

    // Drive to the bottom boundary and beyond
    for (int i = 0; i < 121; i++) step(0, 1, 0, 0, 1, i[0]);
    step(0, 1, 1, 2, 3, 1);
    step(0, 0, 0, 0, 0, 0);
    // Drive to the top boundary and beyond
    for (int i = 0; i < 120; i++) step(1, 0, 1, 1, 6, 0);

    // Asynchronous reset in the middle of a sprite
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    #2 reset_n = 1'b0;
    y_pos_mod = 0; y_neg_mod = 0; write_en = 0;
    #1;
    check_value("arst_x_out", int'(x_out), 0);
    check_value("arst_y_out", int'(y_out), 0);
    check_value("arst_colour", int'(colour_out), 0);
    check_value("arst_plot", int'(plot), 0);
    check_value("arst_ship_y", int'(ship_y), 58);
    #2 reset_n = 1'b1;
    model_y = 58;
    model_pix = 0;
    for (int i = 0; i < 6; i++) step(0, 0, i[0], i / 2, 4, 1);

    // Random mix
    for (int i = 0; i < 150; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3) != 0);

    check_value("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/datapath_player.md
# datapath_player

Datapath that executes the player-ship draw commands issued by the player control FSM. It owns the ship's vertical position register, applies up/down move strobes with boundary handling, and converts per-cycle pixel offsets into absolute VGA (x, y, colour, plot) writes for the 160x120 frame buffer adapter. It also tracks pixel-write progress and flags when a full 2x3 ship sprite has been written.

## Interface
Parameters:
- X_POS, 8'd4: fixed ship column (left pixel).
- Y_INIT, 7'd58: ship top row after reset.
- Y_MIN, 7'd0: lowest legal top row.
- Y_MAX, 7'd117: highest legal top row (120 - sprite height 3).
- STEP, 7'd1: rows moved per strobe.

Ports:
- clk, in, 1: system clock; all state on rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- y_pos_mod, in, 1: move ship up one STEP (toward row 0).
- y_neg_mod, in, 1: move ship down one STEP (toward row 119).
- add_x, in, 1: pixel column offset within sprite (0..1).
- add_y, in, 2: pixel row offset within sprite (0..2; 3 illegal).
- colour_in, in, 3: pixel colour for this cycle.
- write_en, in, 1: pixel write request for this cycle.
- continue_draw, in, 1: controller idle/ending sequence.
- x_out, out, 8: VGA pixel column.
- y_out, out, 7: VGA pixel row.
- colour_out, out, 3: VGA pixel colour.
- plot, out, 1: VGA write strobe.
- ship_y, out, 7: current ship top row.
- at_top, out, 1: ship_y == Y_MIN (combinational from ship_y).
- at_bottom, out, 1: ship_y == Y_MAX (combinational from ship_y).
- frame_done, out, 1: one-cycle pulse when sixth sprite pixel has been written.

## Operation
- y_next: if y_pos_mod and not y_neg_mod: ship_y - STEP, clamped to Y_MIN (compare before subtract; no 7-bit underflow). If y_neg_mod and not y_pos_mod: ship_y + STEP, clamped to Y_MAX (compute in 8 bits). Both or neither: ship_y unchanged.
- ship_y <= y_next every cycle.
- Pixel address uses y_next, so a write in the same cycle as a move strobe lands at the new position.
- x_out <= X_POS + add_x; y_out <= y_next + add_y; colour_out <= colour_in; plot <= write_en. Registered every cycle regardless of write_en.
- add_y == 3: plot forced 0 that cycle; x_out/y_out/colour_out still update.
- Pixel counter pix_cnt (3 bits): on any move strobe, pix_cnt <= write_en ? 1 : 0; else on write_en, pix_cnt <= pix_cnt + 1, saturating at 6.
- frame_done <= 1 exactly on the cycle pix_cnt transitions 5 -> 6; else 0.
- continue_draw: when asserted with no write_en and no move strobe, pix_cnt holds; no other effect (consumed for completeness of the command interface).

## Timing
- Reset values: ship_y = Y_INIT, x_out = 0, y_out = 0, colour_out = 0, plot = 0, pix_cnt = 0, frame_done = 0; at_top/at_bottom follow ship_y.
- Latency: command inputs in cycle N -> VGA outputs and ship_y valid after edge N+1 (one register stage). frame_done asserted in the cycle after the sixth write is sampled.
- No backpressure: VGA adapter accepts one pixel per cycle when plot = 1.
- Reset asserted mid-sequence: all state returns to reset values immediately; partial sprite abandoned; frame_done never pulses for it.
- Move strobe at boundary: position holds, writes still occur at the clamped position.

## Configuration
- PLAYER_WRAP_EN defined: moves wrap instead of clamp: up from Y_MIN -> Y_MAX, down from Y_MAX -> Y_MIN; at_top/at_bottom unchanged in meaning.
- Not defined: clamping as described in Operation.

## Test plan
- Reset: release reset_n with no commands -> ship_y = 58, plot = 0, frame_done = 0, at_top = at_bottom = 0.
- Up sequence: cycle 1 y_pos_mod = 1, write_en = 1, offsets (0,0), colour 0; then (1,0) c0, (0,1) c7, (1,1) c7, (0,2) c0, (1,2) c0 -> ship_y = 57; plot writes at (4,57),(5,57),(4,58),(5,58),(4,59),(5,59) with colours 0,0,7,7,0,0; frame_done single pulse one cycle after the last write.
- Boundary clamp: drive 120 consecutive y_neg_mod strobes from reset -> ship_y stops at 117, at_bottom = 1; further strobe keeps 117. With PLAYER_WRAP_EN: one more strobe -> ship_y = 0, at_top = 1.
- Simultaneous strobes: y_pos_mod = y_neg_mod = 1 with write_en at (1,2) -> ship_y unchanged, write at (5, ship_y + 2), pix_cnt = 1.
- Illegal offset: add_y = 3 with write_en = 1 -> plot = 0 next cycle, pix_cnt still increments.
- Async reset mid-sprite: assert reset_n low after 3 writes, between clock edges -> outputs zero immediately, ship_y = 58; after release, no frame_done pulse without six new writes.
